// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Digit-serial adder/subtractor. Two WIDTH-bit operands are loaded in parallel
// on an accepted start. The unit then consumes DIGIT bits per cycle, LSB first,
// through a DIGIT-bit ripple adder whose carry is held in a register between
// cycles. Subtraction is a + ~b + 1: the inverted operand is loaded and the
// carry register is preset to 1.
//
// Ports
//   clk       rising-edge clock
//   reset_    asynchronous active-low reset
//   start     request a new operation (accepted in IDLE or DONE)
//   sub       0 = a+b, 1 = a-b, sampled with start
//   a, b      WIDTH-bit operands, sampled with start
//   busy      high while digits are being processed
//   done      one-cycle pulse when sum/carry/overflow update
//   sum       result, held until the next completion
//   carry     carry out of the MSB (not-borrow for subtract)
//   overflow  two's-complement signed overflow of the result
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CYCLES = WIDTH / DIGIT;
    localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   a_q,       a_d;
    logic [WIDTH-1:0]   b_q,       b_d;
    logic               cin_q,     cin_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   res_q,     res_d;
    logic               a_msb_q,   a_msb_d;
    logic               b_msb_q,   b_msb_d;
    logic [WIDTH-1:0]   sum_q,     sum_d;
    logic               carry_q,   carry_d;
    logic               ovf_q,     ovf_d;

    logic [DIGIT-1:0]   dig_sum;
    logic               dig_cout;
    logic [WIDTH-1:0]   res_next;
    logic [WIDTH-1:0]   b_eff;

    // DIGIT-bit ripple adder on the low digit of the shift registers.
    always_comb begin
        logic c;
        c       = cin_q;
        dig_sum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dig_sum[i] = a_q[i] ^ b_q[i] ^ c;
            c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        dig_cout = c;
    end

    // New digit enters from the MSB side, so after CYCLES shifts the first
    // digit computed has reached bit 0.
    assign res_next = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
    assign b_eff    = sub ? ~b : b;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b_eff;
                    cin_d   = sub;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                cin_d = dig_cout;
                res_d = res_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    sum_d   = res_next;
                    carry_d = dig_cout;
                    // a_msb ^ b_msb ^ result_msb recovers the carry into the
                    // MSB; XOR with the carry out gives signed overflow.
                    ovf_d   = a_msb_q ^ b_msb_q ^ res_next[WIDTH-1] ^ dig_cout;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign sum      = sum_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule
